// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// latched request layout and latency helpers.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned DEF_DEPTH_LOG2 = 10;
    localparam int unsigned DEF_RD_LAT     = 2;
    localparam int unsigned DEF_WR_LAT     = 1;
    localparam int unsigned MAX_LAT        = 15;

    // Word address drops the byte offset; bits [1:0] of the bus address carry no meaning.
    typedef struct packed {
        logic [3:0]  wen;
        logic [29:0] waddr;
        logic [31:0] wdata;
    } req_t;

    function automatic logic lat_legal(input int unsigned lat);
        return (lat >= 32'd1) && (lat <= MAX_LAT);
    endfunction

    function automatic logic [3:0] lat_to_cnt(input int unsigned lat);
        return 4'(lat - 32'd1);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core data-memory port: request from the core, data/stall/error back from the responder.
interface dmem_responder_if;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        mem_addr_err;

    modport master (
        output mem_en, mem_wen, mem_addr, mem_wdata,
        input  mem_rdata, mem_stall, mem_addr_err
    );

    modport slave (
        input  mem_en, mem_wen, mem_addr, mem_wdata,
        output mem_rdata, mem_stall, mem_addr_err
    );
endinterface

// File: rtl/dmem_word_array.sv
// Single-port synchronous word RAM with byte write-enables.
// Read-before-write output register; contents are never reset.
module dmem_word_array #(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [AW-1:0] idx_i,
    input  logic [3:0]    wen_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [0:(1 << AW) - 1];
    logic [31:0] rdata_q;

    // Old word is captured on the same edge that applies the byte writes.
    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_q <= mem_q[idx_i];
            for (int i = 0; i < 4; i++) begin
                if (wen_i[i]) begin
                    mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Variable-latency data-memory responder: latches a request, stalls the core
// for the configured latency, then completes the access against the word array.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int unsigned RD_LAT     = DEF_RD_LAT,
    parameter int unsigned WR_LAT     = DEF_WR_LAT
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  mem
);

    if (!lat_legal(RD_LAT)) begin : g_bad_rd_lat
        $error("dmem_responder: RD_LAT must be within 1..15");
    end
    if (!lat_legal(WR_LAT)) begin : g_bad_wr_lat
        $error("dmem_responder: WR_LAT must be within 1..15");
    end

    localparam logic [3:0] RD_CNT = lat_to_cnt(RD_LAT);
    localparam logic [3:0] WR_CNT = lat_to_cnt(WR_LAT);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;
    req_t        live_s, cur_s;
    logic        err_q;
    logic        rsel_q;
    logic        in_range_s;
    logic        ram_en_s;
    logic [31:0] ram_rdata_s;
    logic        unused_addr_lsb_s;

    assign live_s            = {mem.mem_wen, mem.mem_addr[31:2], mem.mem_wdata};
    assign unused_addr_lsb_s = ^mem.mem_addr[1:0];

    // Next-state, counter and request-latch logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (mem.mem_en) begin
                    req_d   = live_s;
                    cnt_d   = (live_s.wen == 4'b0000) ? RD_CNT : WR_CNT;
                    state_d = (cnt_d == 4'd0) ? ST_DONE : ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // A latency-1 access completes on its acceptance edge, so it must use the live bus.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_s = live_s;
        end else begin
            cur_s = req_q;
        end
    end

    assign in_range_s = (cur_s.waddr[29:DEPTH_LOG2] == '0);
    // Gating on rst keeps an access from landing while reset is held.
    assign ram_en_s   = ~rst & (state_d == ST_DONE) & in_range_s;

    // FSM, counter, request latch and completion flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            err_q   <= 1'b0;
            rsel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            if (state_d == ST_DONE) begin
                err_q  <= ~in_range_s;
                rsel_q <= in_range_s;
            end else begin
                err_q  <= 1'b0;
            end
        end
    end

    dmem_word_array #(
        .AW (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .en_i    (ram_en_s),
        .idx_i   (cur_s.waddr[DEPTH_LOG2-1:0]),
        .wen_i   (cur_s.wen),
        .wdata_i (cur_s.wdata),
        .rdata_o (ram_rdata_s)
    );

    // rsel_q selects zero after reset or an out-of-range completion; the RAM register holds otherwise.
    assign mem.mem_rdata    = rsel_q ? ram_rdata_s : 32'h0000_0000;
    assign mem.mem_stall    = ~rst & (((state_q == ST_IDLE) & mem.mem_en) | (state_q == ST_BUSY));
    assign mem.mem_addr_err = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_LOG2=10, RD_LAT=2, WR_LAT=1):
// table of single accesses plus hand-written reset and back-to-back sequences.
module tb_dmem_responder;

    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;
    localparam int NVEC   = 17;

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    dmem_responder_if mem_if ();

    dmem_responder #(
        .DEPTH_LOG2 (10),
        .RD_LAT     (RD_LAT),
        .WR_LAT     (WR_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mem (mem_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        mem_if.mem_en    = 1'b0;
        mem_if.mem_wen   = 4'b0000;
        mem_if.mem_addr  = 32'h0;
        mem_if.mem_wdata = 32'h0;
    endtask

    // Drives one access, checks the stall profile, DONE outputs and the error pulse ending.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        lat = (v.wen == 4'b0000) ? RD_LAT : WR_LAT;
        mem_if.mem_en    = 1'b1;
        mem_if.mem_wen   = v.wen;
        mem_if.mem_addr  = v.addr;
        mem_if.mem_wdata = v.wdata;
        for (int c = 0; c < lat; c++) begin
            #1;
            check($sformatf("v%0d_stall_c%0d", idx, c), {31'b0, mem_if.mem_stall}, 32'd1);
            @(negedge clk);
        end
        #1;
        check($sformatf("v%0d_done_stall", idx), {31'b0, mem_if.mem_stall}, 32'd0);
        if (v.chk_rd) begin
            check($sformatf("v%0d_rdata", idx), mem_if.mem_rdata, v.exp_rd);
        end
        check($sformatf("v%0d_err", idx), {31'b0, mem_if.mem_addr_err}, {31'b0, v.exp_err});
        drive_idle();
        @(negedge clk);
        #1;
        check($sformatf("v%0d_err_end", idx), {31'b0, mem_if.mem_addr_err}, 32'd0);
        check($sformatf("v%0d_idle_stall", idx), {31'b0, mem_if.mem_stall}, 32'd0);
    endtask

    initial begin
        int          nd;
        int          dc [2];
        logic [31:0] dr [2];

        //            wen      addr          wdata         chk   exp_rd        err
        vecs[0]  = '{4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0,         1'b0};
        vecs[1]  = '{4'hF, 32'h0000_0020, 32'h5555_5555, 1'b0, 32'h0,         1'b0};
        vecs[2]  = '{4'hF, 32'h0000_0044, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b0};
        vecs[3]  = '{4'hF, 32'h0000_0080, 32'h0BAD_0080, 1'b0, 32'h0,         1'b0};
        vecs[4]  = '{4'h0, 32'h0000_0020, 32'h0,         1'b1, 32'h5555_5555, 1'b0};
        vecs[5]  = '{4'h0, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_0000, 1'b0};
        vecs[6]  = '{4'h0, 32'h0000_0020, 32'h0,         1'b1, 32'h5555_5555, 1'b0};
        vecs[7]  = '{4'hF, 32'h0000_0040, 32'h1234_5678, 1'b0, 32'h0,         1'b0};
        vecs[8]  = '{4'h0, 32'h0000_0040, 32'h0,         1'b1, 32'h1234_5678, 1'b0};
        vecs[9]  = '{4'h2, 32'h0000_0040, 32'h0000_AB00, 1'b1, 32'h1234_5678, 1'b0};
        vecs[10] = '{4'h0, 32'h0000_0040, 32'h0,         1'b1, 32'h1234_AB78, 1'b0};
        vecs[11] = '{4'h0, 32'h0001_0000, 32'h0,         1'b1, 32'h0000_0000, 1'b1};
        vecs[12] = '{4'hF, 32'h0000_1040, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b1};
        vecs[13] = '{4'h0, 32'h0000_0040, 32'h0,         1'b1, 32'h1234_AB78, 1'b0};
        vecs[14] = '{4'h9, 32'h0000_0044, 32'h1100_0022, 1'b1, 32'hCAFE_F00D, 1'b0};
        vecs[15] = '{4'h0, 32'h0000_0047, 32'h0,         1'b1, 32'h11FE_F022, 1'b0};
        vecs[16] = '{4'h0, 32'h0000_0080, 32'h0,         1'b1, 32'h0BAD_0080, 1'b0};

        // Reset state, including stall forced low while a request is presented.
        drive_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        mem_if.mem_en = 1'b1;
        #1;
        check("rst_stall", {31'b0, mem_if.mem_stall}, 32'd0);
        check("rst_rdata", mem_if.mem_rdata, 32'h0);
        check("rst_err", {31'b0, mem_if.mem_addr_err}, 32'd0);
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset while a write of 0xAAAA_AAAA to 0x20 is in flight.
        mem_if.mem_en    = 1'b1;
        mem_if.mem_wen   = 4'hF;
        mem_if.mem_addr  = 32'h0000_0020;
        mem_if.mem_wdata = 32'hAAAA_AAAA;
        #1;
        check("t1_stall_pre", {31'b0, mem_if.mem_stall}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t1_stall_rst", {31'b0, mem_if.mem_stall}, 32'd0);
        check("t1_rdata_rst", mem_if.mem_rdata, 32'h0);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the BUSY cycle of a read.
        mem_if.mem_en   = 1'b1;
        mem_if.mem_addr = 32'h0000_0040;
        @(negedge clk);
        drive_idle();
        #1;
        check("t1b_busy_stall", {31'b0, mem_if.mem_stall}, 32'd1);
        rst = 1'b1;
        #1;
        check("t1b_rst_stall", {31'b0, mem_if.mem_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("t1b_after_stall", {31'b0, mem_if.mem_stall}, 32'd0);
        check("t1b_after_rdata", mem_if.mem_rdata, 32'h0);
        @(negedge clk);

        for (int i = 5; i < 16; i++) begin
            run_vec(vecs[i], i);
        end

        // Back-to-back reads of 0x40 then 0x44; BUSY-period garbage must be ignored.
        nd    = 0;
        dc[0] = -1;
        dc[1] = -1;
        dr[0] = 32'h0;
        dr[1] = 32'h0;
        mem_if.mem_en    = 1'b1;
        mem_if.mem_wen   = 4'h0;
        mem_if.mem_addr  = 32'h0000_0040;
        mem_if.mem_wdata = 32'h0;
        for (int c = 0; c < 12 && nd < 2; c++) begin
            #1;
            if (!mem_if.mem_stall) begin
                dc[nd] = c;
                dr[nd] = mem_if.mem_rdata;
                nd++;
                if (nd == 1) begin
                    mem_if.mem_en    = 1'b1;
                    mem_if.mem_wen   = 4'h0;
                    mem_if.mem_addr  = 32'h0000_0044;
                    mem_if.mem_wdata = 32'h0;
                end else begin
                    drive_idle();
                end
            end else if (c == 1) begin
                mem_if.mem_en    = 1'b0;
                mem_if.mem_wen   = 4'hF;
                mem_if.mem_addr  = 32'h0000_0080;
                mem_if.mem_wdata = 32'hFFFF_FFFF;
            end
            @(negedge clk);
        end
        drive_idle();
        check("b2b_done_count", nd, 32'd2);
        check("b2b_done0_cycle", dc[0], RD_LAT);
        check("b2b_done1_cycle", dc[1], 2 * RD_LAT + 1);
        check("b2b_rdata0", dr[0], 32'h1234_AB78);
        check("b2b_rdata1", dr[1], 32'h11FE_F022);

        run_vec(vecs[16], 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
